// File: rtl/host_mem_sequencer_pkg.sv
// Shared definitions for the host memory sequencer: command opcodes,
// FSM state encoding and default timing constants.
package host_seq_pkg;

    typedef enum logic [1:0] {
        OP_LD_IRAM  = 2'b00,
        OP_LD_DRAM  = 2'b01,
        OP_RUN      = 2'b10,
        OP_READBACK = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_L_FETCH,
        S_L_SETUP,
        S_L_STROBE,
        S_L_HOLD,
        S_R_ARG,
        S_R_RUN,
        S_R_END,
        S_B_ADDR,
        S_B_RD,
        S_B_SEND
    } state_e;

    localparam int unsigned DEF_ADDR_W    = 9;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_BASE_ADDR = 1;
    localparam int unsigned DEF_WR_SETUP  = 2;
    localparam int unsigned DEF_WR_PULSE  = 4;
    localparam int unsigned DEF_WR_HOLD   = 2;
    localparam int unsigned DEF_RD_LAT    = 4;
    localparam int unsigned DEF_RUN_SHIFT = 4;

    // Width of the shared wait timer (run length is up to 24 bits).
    localparam int unsigned TMR_W = 24;

endpackage

// File: rtl/host_mem_sequencer_if.sv
// Command and readback valid/ready streams between the host link and the sequencer.
interface host_mem_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/host_mem_sequencer_timer.sv
// Loadable down-counter with zero flag; a state that loads N-1 on entry
// and leaves when the flag is set lasts exactly N cycles.
module seq_timer
    import host_seq_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority; otherwise count down and stick at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/host_mem_sequencer.sv
// Command-driven sequencer feeding top_control's external-access ports:
// loads IRAM/DRAM, runs the core for a commanded length and streams DRAM back.
module host_mem_sequencer
    import host_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WR_SETUP  = DEF_WR_SETUP,
    parameter int unsigned WR_PULSE  = DEF_WR_PULSE,
    parameter int unsigned WR_HOLD   = DEF_WR_HOLD,
    parameter int unsigned RD_LAT    = DEF_RD_LAT,
    parameter int unsigned RUN_SHIFT = DEF_RUN_SHIFT
) (
    input  logic                clock,
    input  logic                reset_n,
    host_mem_sequencer_if.slave host,
    output logic                busy,
    output logic                start,
    output logic                start_2,
    output logic                start_3,
    output logic                start_4,
    output logic [ADDR_W-1:0]   addr_ext,
    output logic                iram_write_ext,
    output logic                dram_write_ext,
    output logic                read_en_ext,
    output logic [DATA_W-1:0]   Data_in_ins,
    output logic [DATA_W-1:0]   Data_in_dram,
    input  logic [DATA_W-1:0]   dram_in
);

    localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(WR_SETUP - 1);
    localparam logic [TMR_W-1:0] T_PULSE = TMR_W'(WR_PULSE - 1);
    localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(WR_HOLD - 1);
    localparam logic [TMR_W-1:0] T_RD    = TMR_W'(RD_LAT - 1);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [ADDR_W-1:0]  r_remain;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_din_ins;
    logic [DATA_W-1:0]  r_din_dram;
    logic [DATA_W-1:0]  r_mdata;
    logic               r_en;

    logic               w_s_ready;
    logic               w_accept;
    op_e                w_hdr_op;
    logic [ADDR_W-1:0]  w_hdr_cnt;
    logic [TMR_W-1:0]   w_run_len;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_zero;
    logic               w_load_state;

    assign w_accept  = host.s_valid & w_s_ready;
    assign w_hdr_op  = op_e'(host.s_data[DATA_W-1 -: 2]);
    assign w_hdr_cnt = host.s_data[ADDR_W-1:0];
    assign w_run_len = TMR_W'(host.s_data) << RUN_SHIFT;

    seq_timer #(.W(TMR_W)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_zero  (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, command ready and timer load decisions.
    always_comb begin
        w_next     = r_state;
        w_s_ready  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            S_IDLE: begin
                w_s_ready = r_en;
                if (w_accept) begin
                    case (w_hdr_op)
                        OP_LD_IRAM, OP_LD_DRAM: w_next = S_L_FETCH;
                        OP_RUN:                 w_next = S_R_ARG;
                        default:                w_next = S_B_ADDR;
                    endcase
                end
            end
            S_L_FETCH: begin
                w_s_ready = (r_remain != '0);
                if (r_remain == '0) begin
                    w_next = S_IDLE;
                end else if (w_accept) begin
                    w_next     = S_L_SETUP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = T_SETUP;
                end
            end
            S_L_SETUP: begin
                if (w_tmr_zero) begin
                    w_next     = S_L_STROBE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = T_PULSE;
                end
            end
            S_L_STROBE: begin
                if (w_tmr_zero) begin
                    w_next     = S_L_HOLD;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = T_HOLD;
                end
            end
            S_L_HOLD: begin
                if (w_tmr_zero) begin
                    w_next = (r_remain == '0) ? S_IDLE : S_L_FETCH;
                end
            end
            S_R_ARG: begin
                w_s_ready = 1'b1;
                if (w_accept) begin
                    if (w_run_len == '0) begin
                        w_next = S_R_END;
                    end else begin
                        w_next     = S_R_RUN;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = w_run_len - 1'b1;
                    end
                end
            end
            S_R_RUN: begin
                if (w_tmr_zero) begin
                    w_next = S_R_END;
                end
            end
            S_R_END: begin
                w_next = S_IDLE;
            end
            S_B_ADDR: begin
                w_s_ready = 1'b1;
                if (w_accept) begin
                    if (r_remain == '0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next     = S_B_RD;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = T_RD;
                    end
                end
            end
            S_B_RD: begin
                if (w_tmr_zero) begin
                    w_next = S_B_SEND;
                end
            end
            S_B_SEND: begin
                if (host.m_ready) begin
                    if (r_remain == ADDR_W'(1)) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next     = S_B_RD;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = T_RD;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: command fields, word counter, address, write data and readback capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= OP_LD_IRAM;
            r_remain   <= '0;
            r_addr     <= '0;
            r_din_ins  <= '0;
            r_din_dram <= '0;
            r_mdata    <= '0;
            r_en       <= 1'b0;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_hdr_op;
                        r_remain <= w_hdr_cnt;
                        if (w_hdr_op == OP_LD_IRAM || w_hdr_op == OP_LD_DRAM) begin
                            r_addr <= ADDR_W'(BASE_ADDR);
                        end
                    end
                end
                S_L_FETCH: begin
                    if (w_accept) begin
                        r_remain <= r_remain - 1'b1;
                        if (r_op == OP_LD_IRAM) begin
                            r_din_ins <= host.s_data;
                        end else begin
                            r_din_dram <= host.s_data;
                        end
                    end
                end
                S_L_HOLD: begin
                    if (w_tmr_zero) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_B_ADDR: begin
                    if (w_accept) begin
                        r_addr <= host.s_data[ADDR_W-1:0];
                    end
                end
                S_B_RD: begin
                    if (w_tmr_zero) begin
                        r_mdata <= dram_in;
                    end
                end
                S_B_SEND: begin
                    if (host.m_ready) begin
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears every strobe at once.
    assign w_load_state = (r_state == S_L_FETCH) || (r_state == S_L_SETUP) ||
                          (r_state == S_L_STROBE) || (r_state == S_L_HOLD);

    assign busy           = (r_state != S_IDLE);
    assign start          = (r_state == S_R_RUN);
    assign start_2        = w_load_state && (r_op == OP_LD_IRAM);
    assign start_3        = w_load_state && (r_op == OP_LD_DRAM);
    assign start_4        = (r_state == S_B_ADDR) || (r_state == S_B_RD) || (r_state == S_B_SEND);
    assign iram_write_ext = (r_state == S_L_STROBE) && (r_op == OP_LD_IRAM);
    assign dram_write_ext = (r_state == S_L_STROBE) && (r_op == OP_LD_DRAM);
    assign read_en_ext    = (r_state == S_B_RD);
    assign addr_ext       = r_addr;
    assign Data_in_ins    = r_din_ins;
    assign Data_in_dram   = r_din_dram;
    assign host.s_ready   = w_s_ready;
    assign host.m_valid   = (r_state == S_B_SEND);
    assign host.m_data    = r_mdata;

endmodule

// File: tb/tb_host_mem_sequencer.sv
// Directed bench for host_mem_sequencer with a transaction-level model:
// commands push expected writes/runs/reads, one negedge monitor checks them.
module tb_host_mem_sequencer;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BASE   = 1;
    localparam int unsigned WR_SETUP = 2;
    localparam int unsigned WR_PULSE = 4;
    localparam int unsigned WR_HOLD  = 2;
    localparam int unsigned RD_LAT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, start, start_2, start_3, start_4;
    logic iram_write_ext, dram_write_ext, read_en_ext;
    logic [ADDR_W-1:0] addr_ext;
    logic [DATA_W-1:0] Data_in_ins, Data_in_dram, dram_in;
    logic [DATA_W-1:0] mem [0:511];

    host_mem_sequencer_if #(.DATA_W(DATA_W)) bus ();

    host_mem_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE),
        .WR_SETUP(WR_SETUP), .WR_PULSE(WR_PULSE), .WR_HOLD(WR_HOLD),
        .RD_LAT(RD_LAT), .RUN_SHIFT(4)
    ) dut (
        .clock(clk), .reset_n(rst_n), .host(bus),
        .busy(busy), .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
        .addr_ext(addr_ext), .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
        .read_en_ext(read_en_ext), .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
        .dram_in(dram_in)
    );

    always #5 clk = ~clk;
    assign dram_in = mem[addr_ext];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model state: expected transactions in issue order.
    logic              exp_wr_m [$];
    logic [ADDR_W-1:0] exp_wr_a [$];
    logic [DATA_W-1:0] exp_wr_d [$];
    int                exp_run  [$];
    logic [ADDR_W-1:0] exp_rd_a [$];
    logic [DATA_W-1:0] exp_rd_d [$];
    logic [2:0]        exp_sel = 3'b000;

    // Observations recorded by the monitor.
    logic [DATA_W-1:0] obs_iram [0:511];
    logic [DATA_W-1:0] obs_dram [0:511];
    logic [DATA_W-1:0] rx [0:15];
    int n_rx = 0;
    int last_run_len = 0;
    int start_rises = 0;
    int t_fall = 0;

    // Monitor-private tracking.
    logic prev_wr = 0, prev_start = 0, prev_rd = 0, prev_mv = 0, prev_hs = 0;
    logic wr_now, wr_is_dram;
    int wr_len = 0, hold_left = 0, run_len = 0, rd_len = 0;
    logic [ADDR_W-1:0] wr_a, cap_a;
    logic [DATA_W-1:0] wr_d, cap_d, cur_d;
    logic [ADDR_W-1:0] hist_a [0:1];
    logic [DATA_W-1:0] hist_di [0:1];
    logic [DATA_W-1:0] hist_dd [0:1];

    // Compare process: every cycle out of reset, check outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 0; prev_start = 0; prev_rd = 0; prev_mv = 0; prev_hs = 0;
            wr_len = 0; hold_left = 0; run_len = 0; rd_len = 0;
        end else begin
            wr_now = iram_write_ext | dram_write_ext;
            if (busy) chk("select", {29'd0, start_2, start_3, start_4}, {29'd0, exp_sel});
            chk("one_hot", 32'($countones({start, start_2, start_3, start_4}) <= 1), 1);
            chk("rd_en_vs_valid", {31'd0, read_en_ext & bus.m_valid}, 0);
            // Write strobe: content, setup, width, hold.
            if (wr_now && !prev_wr) begin
                wr_len = 1;
                wr_is_dram = dram_write_ext;
                wr_a = addr_ext;
                wr_d = dram_write_ext ? Data_in_dram : Data_in_ins;
                chk("setup_addr", {23'd0, hist_a[1]}, {23'd0, addr_ext});
                chk("setup_data", {16'd0, wr_is_dram ? hist_dd[1] : hist_di[1]}, {16'd0, wr_d});
                if (exp_wr_a.size() == 0) begin
                    chk("unexpected_write", 0, 1);
                end else begin
                    chk("wr_mem", {31'd0, wr_is_dram}, {31'd0, exp_wr_m.pop_front()});
                    chk("wr_addr", {23'd0, wr_a}, {23'd0, exp_wr_a.pop_front()});
                    chk("wr_data", {16'd0, wr_d}, {16'd0, exp_wr_d.pop_front()});
                end
                if (wr_is_dram) obs_dram[wr_a] = wr_d; else obs_iram[wr_a] = wr_d;
            end else if (wr_now) begin
                wr_len++;
                cur_d = wr_is_dram ? Data_in_dram : Data_in_ins;
                chk("pulse_strobe", {31'd0, dram_write_ext}, {31'd0, wr_is_dram});
                chk("pulse_addr", {23'd0, addr_ext}, {23'd0, wr_a});
                chk("pulse_data", {16'd0, cur_d}, {16'd0, wr_d});
            end else if (prev_wr) begin
                chk("pulse_width", wr_len, WR_PULSE);
                t_fall = cyc;
                hold_left = WR_HOLD;
            end
            if (!wr_now && hold_left > 0) begin
                cur_d = wr_is_dram ? Data_in_dram : Data_in_ins;
                chk("hold_addr", {23'd0, addr_ext}, {23'd0, wr_a});
                chk("hold_data", {16'd0, cur_d}, {16'd0, wr_d});
                hold_left--;
            end
            // Run pulse length.
            if (start) run_len++;
            if (start && !prev_start) start_rises++;
            if (!start && prev_start) begin
                last_run_len = run_len;
                if (exp_run.size() == 0) chk("unexpected_run", 0, 1);
                else chk("run_len", run_len, exp_run.pop_front());
                run_len = 0;
            end
            // Read latency.
            if (read_en_ext) rd_len++;
            else if (prev_rd) begin
                chk("rd_lat", rd_len, RD_LAT);
                rd_len = 0;
            end
            // Readback stream.
            if (prev_mv && !prev_hs) chk("mvalid_hold", {31'd0, bus.m_valid}, 1);
            if (bus.m_valid) begin
                if (!prev_mv || prev_hs) begin
                    cap_d = bus.m_data;
                    cap_a = addr_ext;
                    if (exp_rd_a.size() == 0) begin
                        chk("unexpected_read", 0, 1);
                    end else begin
                        chk("rd_addr", {23'd0, addr_ext}, {23'd0, exp_rd_a.pop_front()});
                        chk("rd_data", {16'd0, bus.m_data}, {16'd0, exp_rd_d.pop_front()});
                    end
                end else begin
                    chk("m_data_stable", {16'd0, bus.m_data}, {16'd0, cap_d});
                    chk("rd_addr_stable", {23'd0, addr_ext}, {23'd0, cap_a});
                end
                if (bus.m_ready && n_rx < 16) begin
                    rx[n_rx] = bus.m_data;
                    n_rx++;
                end
            end
            prev_hs = bus.m_valid & bus.m_ready;
            prev_mv = bus.m_valid;
            prev_wr = wr_now;
            prev_start = start;
            prev_rd = read_en_ext;
        end
        hist_a[1] = hist_a[0];   hist_a[0] = addr_ext;
        hist_di[1] = hist_di[0]; hist_di[0] = Data_in_ins;
        hist_dd[1] = hist_dd[0]; hist_dd[0] = Data_in_dram;
    end

    // All drive tasks start and end at posedge+1.
    task automatic send_word(input logic [15:0] w);
        int unsigned n = 0;
        logic rdy;
        bus.s_valid = 1'b1;
        bus.s_data = w;
        do begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 2000);
        if (!rdy) chk("s_ready_timeout", 0, 1);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [1:0] op, input int unsigned cnt, input logic [2:0] sel);
        send_word({op, 5'b0, 9'(cnt)});
        exp_sel = sel;
    endtask

    task automatic wait_idle(output int n, output int c);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 5000);
        c = cyc;
        if (busy) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic is_dram, input int unsigned cnt,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input int unsigned gap);
        logic [15:0] w [3];
        int unsigned n;
        w = '{d0, d1, d2};
        for (int unsigned i = 0; i < cnt; i++) begin
            exp_wr_m.push_back(is_dram);
            exp_wr_a.push_back(9'(BASE + i));
            exp_wr_d.push_back(w[i]);
        end
        send_hdr(is_dram ? 2'b01 : 2'b00, cnt, is_dram ? 3'b010 : 3'b100);
        for (int unsigned i = 0; i < cnt; i++) begin
            if (gap > 0) begin
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.s_ready && n < 100);
                if (!bus.s_ready) chk("fetch_timeout", 0, 1);
                for (int unsigned g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("stall_strobe", {31'd0, iram_write_ext | dram_write_ext}, 0);
                    chk("stall_ready", {31'd0, bus.s_ready}, 1);
                end
                @(posedge clk);
                #1;
            end
            send_word(w[i]);
        end
    endtask

    task automatic do_readback(input logic [ADDR_W-1:0] a, input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) begin
            exp_rd_a.push_back(a + 9'(i));
            exp_rd_d.push_back(mem[a + 9'(i)]);
        end
        send_hdr(2'b11, cnt, 3'b001);
        send_word({7'd0, a});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, rises;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        mem[300] = 16'hBEEF; mem[301] = 16'h1234;
        mem[511] = 16'hA5A5; mem[0]   = 16'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {24'd0, busy, start, start_2, start_3, start_4,
                            iram_write_ext, dram_write_ext, read_en_ext}, 0);
        chk("rst_handshake", {30'd0, bus.s_ready, bus.m_valid}, 0);
        chk("rst_addr", {23'd0, addr_ext}, 0);
        chk("rst_data", {Data_in_ins, Data_in_dram}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: IRAM load of three words.
        do_load(1'b0, 3, 16'd10, 16'd20, 16'd30, 0);
        wait_idle(n, c);
        chk("busy_fall_after_hold", c - t_fall, WR_HOLD);
        chk("iram1", {16'd0, obs_iram[1]}, 10);
        chk("iram2", {16'd0, obs_iram[2]}, 20);
        chk("iram3", {16'd0, obs_iram[3]}, 30);

        // 2: DRAM load with stalled payloads.
        do_load(1'b1, 2, 16'h1111, 16'h2222, 16'h0, 7);
        wait_idle(n, c);
        chk("dram1", {16'd0, obs_dram[1]}, 32'h1111);
        chk("dram2", {16'd0, obs_dram[2]}, 32'h2222);

        // Empty load returns at once.
        send_hdr(2'b00, 0, 3'b100);
        wait_idle(n, c);
        chk("cnt0_idle_cycles", n, 2);

        // 3: run for 5<<4 cycles, then a zero-length run.
        exp_run.push_back(5 * 16);
        send_hdr(2'b10, 0, 3'b000);
        send_word(16'd5);
        wait_idle(n, c);
        chk("run_80", last_run_len, 80);
        rises = start_rises;
        send_hdr(2'b10, 0, 3'b000);
        send_word(16'd0);
        wait_idle(n, c);
        chk("run0_idle_cycles", n, 2);
        chk("run0_no_start", start_rises, rises);

        // 4: readback with a stalled consumer.
        bus.m_ready = 1'b0;
        do_readback(9'd300, 2);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.m_valid && n < 100);
        chk("mvalid_arrives", {31'd0, bus.m_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rd_en", {31'd0, read_en_ext}, 0);
            chk("stall_m_data", {16'd0, bus.m_data}, 32'hBEEF);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        wait_idle(n, c);
        chk("rx0", {16'd0, rx[0]}, 32'hBEEF);
        chk("rx1", {16'd0, rx[1]}, 32'h1234);

        // 5: readback wrapping past the top address.
        do_readback(9'd511, 2);
        wait_idle(n, c);
        chk("rx_wrap0", {16'd0, rx[2]}, 32'hA5A5);
        chk("rx_wrap1", {16'd0, rx[3]}, 32'h5A5A);
        chk("rx_count", n_rx, 4);

        // 6: reset during the write strobe.
        do_load(1'b0, 1, 16'h7777, 16'h0, 16'h0, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!iram_write_ext && n < 100);
        chk("strobe_before_reset", {31'd0, iram_write_ext}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_strobe_drop", {31'd0, iram_write_ext}, 0);
        chk("async_sel_drop", {31'd0, start_2}, 0);
        chk("async_busy_drop", {31'd0, busy}, 0);
        exp_wr_m.delete(); exp_wr_a.delete(); exp_wr_d.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_load(1'b0, 1, 16'h4242, 16'h0, 16'h0, 0);
        wait_idle(n, c);
        chk("post_reset_load", {16'd0, obs_iram[1]}, 32'h4242);

        chk("wr_queue_empty", exp_wr_a.size(), 0);
        chk("run_queue_empty", exp_run.size(), 0);
        chk("rd_queue_empty", exp_rd_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
